// File: rtl/period_meter.sv
// Measures the period and high time of a slow, possibly asynchronous square wave in clk cycles.
// Results are captured at each rising edge; a stalled input raises a sticky timeout flag.
module period_meter #(
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned TIMEOUT     = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {StWaitFirst, StHigh, StLow} state_e;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       high_cap_q;

  logic s;
  logic rise;
  logic fall;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q     <= '0;
      s_d_q      <= 1'b0;
      state_q    <= StWaitFirst;
      count_q    <= '0;
      high_cap_q <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      edge_rise  <= 1'b0;
      edge_fall  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q      <= s;
      edge_rise  <= rise;
      edge_fall  <= fall;
      meas_valid <= 1'b0;

      if (!enable) begin
        // Captured results and the timeout flag are held while disabled.
        state_q <= StWaitFirst;
        count_q <= '0;
      end else begin
        unique case (state_q)
          StWaitFirst: begin
            if (rise) begin
              count_q <= One;
              state_q <= StHigh;
            end else begin
              count_q <= '0;
            end
          end
          StHigh: begin
            if (rise) begin
              // Missed fall: the whole interval counts as high time.
              period     <= count_q;
              high_time  <= count_q;
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
              count_q    <= One;
            end else if (fall) begin
              high_cap_q <= count_q;
              count_q    <= count_q + One;
              state_q    <= StLow;
            end else if (count_q == TimeoutCnt) begin
              timeout <= 1'b1;
              count_q <= '0;
              state_q <= StWaitFirst;
            end else begin
              count_q <= count_q + One;
            end
          end
          StLow: begin
            if (rise) begin
              period     <= count_q;
              high_time  <= high_cap_q;
              meas_valid <= 1'b1;
              timeout    <= 1'b0;
              count_q    <= One;
              state_q    <= StHigh;
            end else if (count_q == TimeoutCnt) begin
              timeout <= 1'b1;
              count_q <= '0;
              state_q <= StWaitFirst;
            end else begin
              count_q <= count_q + One;
            end
          end
          default: begin
            state_q <= StWaitFirst;
            count_q <= '0;
          end
        endcase
      end
    end
  end

endmodule
